// File: rtl/prbs9_checker_if.sv
// Bundle of the PRBS9 checker's data, strobe and status signals.
// The master side drives the received stream and strobes. The slave side is the checker.
interface prbs9_checker_if #(
  parameter int NB_CNT = 32
);
  logic              i_rx_bit;
  logic [1:0]        i_enable_sample;
  logic              i_EnbRx;
  logic              i_clr_cnt;
  logic              o_lock;
  logic              o_err_pulse;
  logic [NB_CNT-1:0] o_bit_cnt;
  logic [NB_CNT-1:0] o_err_cnt;

  modport master (
    output i_rx_bit, i_enable_sample, i_EnbRx, i_clr_cnt,
    input  o_lock, o_err_pulse, o_bit_cnt, o_err_cnt
  );

  modport slave (
    input  i_rx_bit, i_enable_sample, i_EnbRx, i_clr_cnt,
    output o_lock, o_err_pulse, o_bit_cnt, o_err_cnt
  );
endinterface

// File: rtl/prbs9_checker.sv
// Receive-side PRBS9 (x^9 + x^5 + 1) checker.
// In SEARCH it shifts received bits into its history and waits for LOCK_THR consecutive
// correct predictions. In LOCKED it runs as a free-running local generator and counts
// bit errors against that generator. Too many errors in one window drop it back to SEARCH.
module prbs9_checker #(
  parameter int NB_REG   = 9,
  parameter int NB_CNT   = 32,
  parameter int LOCK_THR = 16,
  parameter int ERR_WIN  = 64,
  parameter int ERR_THR  = 8
) (
  input logic            clk,
  input logic            i_rst,
  prbs9_checker_if.slave bus
);

  localparam int FILL_W  = $clog2(NB_REG + 1);
  localparam int MATCH_W = $clog2(LOCK_THR + 1);
  localparam int WBITS_W = $clog2(ERR_WIN + 1);
  localparam int WERRS_W = $clog2(ERR_THR + 1);

  localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(NB_REG);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_THR - 1);
  localparam logic [WBITS_W-1:0] WBITS_LAST = WBITS_W'(ERR_WIN - 1);
  localparam logic [WERRS_W-1:0] WERRS_LAST = WERRS_W'(ERR_THR - 1);

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [NB_REG-1:0]  h;          // history / local generator register, newest bit in h[0]
  logic [FILL_W-1:0]  fill;       // bits shifted in since entering SEARCH, saturates at NB_REG
  logic [MATCH_W-1:0] match_cnt;  // consecutive correct predictions in SEARCH
  logic [WBITS_W-1:0] win_bits;   // samples in the current LOCKED error window
  logic [WERRS_W-1:0] win_errs;   // errors in the current LOCKED error window
  logic [NB_CNT-1:0]  bit_cnt;
  logic [NB_CNT-1:0]  err_cnt;
  logic               err_pulse;

  logic valid;      // a bit is consumed this cycle
  logic pred;       // bit the PRBS recurrence expects next
  logic err;        // received bit disagrees with the prediction
  logic fill_done;  // history holds a full register's worth of received bits
  logic match;      // SEARCH: prediction confirmed on a non-degenerate history
  logic lock_hit;   // SEARCH: this sample completes the lock run
  logic thr_hit;    // LOCKED: this sample brings the window error count to ERR_THR
  logic win_end;    // LOCKED: this sample closes the error window

  assign valid     = bus.i_EnbRx & (bus.i_enable_sample == 2'b11);
  assign pred      = h[8] ^ h[4];
  assign err       = bus.i_rx_bit ^ pred;
  assign fill_done = (fill == FILL_FULL);
  // An all-zero history trivially predicts 0, so it must never count as a match.
  assign match     = fill_done & ~err & (h != '0);
  assign lock_hit  = valid & match & (match_cnt == MATCH_LAST);
  assign thr_hit   = valid & err & (win_errs == WERRS_LAST);
  assign win_end   = (win_bits == WBITS_LAST);

  // Lock state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesised flops.
    if (i_rst) state <= ST_SEARCH;
    else       state <= state_nxt;
  end

  // Next lock state: acquire after LOCK_THR matches, drop on window error threshold.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      ST_SEARCH: if (lock_hit) state_nxt = ST_LOCKED;
      ST_LOCKED: if (thr_hit)  state_nxt = ST_SEARCH;
      default:                 state_nxt = ST_SEARCH;
    endcase
  end

  // History shift plus SEARCH fill/match tracking; history survives loss of lock.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      h         <= '0;
      fill      <= '0;
      match_cnt <= '0;
    end else if (valid) begin
      if (state == ST_SEARCH) begin
        h <= {h[NB_REG-2:0], bus.i_rx_bit};
        if (!fill_done) fill <= fill + 1'b1;
        if (fill_done)  match_cnt <= match ? match_cnt + 1'b1 : '0;
      end else begin
        // Locked: the received bit is not fed back, so one flipped bit costs exactly one error.
        h <= {h[NB_REG-2:0], pred};
        if (thr_hit) begin
          fill      <= '0;
          match_cnt <= '0;
        end
      end
    end
  end

  // LOCKED error window; loss of lock wins over a same-sample window end.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      win_bits <= '0;
      win_errs <= '0;
    end else if (valid && state == ST_LOCKED) begin
      if (thr_hit || win_end) begin
        win_bits <= '0;
        win_errs <= '0;
      end else begin
        win_bits <= win_bits + 1'b1;
        win_errs <= win_errs + WERRS_W'(err);
      end
    end
  end

  // Saturating bit/error counters and registered error pulse; clear beats increment.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      bit_cnt   <= '0;
      err_cnt   <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= valid & (state == ST_LOCKED) & err;
      if (bus.i_clr_cnt) begin
        bit_cnt <= '0;
        err_cnt <= '0;
      end else if (valid && state == ST_LOCKED) begin
        if (bit_cnt != '1)        bit_cnt <= bit_cnt + 1'b1;
        if (err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  assign bus.o_lock      = (state == ST_LOCKED);
  assign bus.o_err_pulse = err_pulse;
  assign bus.o_bit_cnt   = bit_cnt;
  assign bus.o_err_cnt   = err_cnt;

endmodule

// File: tb/tb_prbs9_checker.sv
// Testbench for prbs9_checker.
// The driver feeds a PRBS9 transmitter stream (with optional bit flips and strobe gaps) and pushes
// the expected outputs of a behavioural model into a queue. A monitor pops them one cycle later.
`timescale 1ns/1ps
module tb_prbs9_checker;

  localparam int NB_CNT   = 32;
  localparam int LOCK_THR = 16;
  localparam int ERR_WIN  = 64;
  localparam int ERR_THR  = 8;
  localparam longint CNT_MAX = (longint'(1) << NB_CNT) - 1;

  logic clk = 1'b0;
  logic i_rst;

  prbs9_checker_if #(.NB_CNT(NB_CNT)) bus ();

  prbs9_checker #(
    .NB_REG  (9),
    .NB_CNT  (NB_CNT),
    .LOCK_THR(LOCK_THR),
    .ERR_WIN (ERR_WIN),
    .ERR_THR (ERR_THR)
  ) dut (
    .clk  (clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit     lock;
    bit     pulse;
    longint bit_cnt;
    longint err_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Transmitter: the next nine bits to send; b[n] = b[n-9] ^ b[n-5].
  bit tx_q[$];

  // Behavioural model of the checker.
  bit     m_locked;
  int     m_fill, m_match, m_wbits, m_werrs;
  bit     m_hist[$];  // last nine register bits, oldest first
  longint m_bc, m_ec;
  bit     m_pulse;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_locked = 1'b0;
    m_fill   = 0;
    m_match  = 0;
    m_wbits  = 0;
    m_werrs  = 0;
    m_bc     = 0;
    m_ec     = 0;
    m_pulse  = 1'b0;
    m_hist.delete();
    for (int i = 0; i < 9; i++) m_hist.push_back(1'b0);
  endfunction

  function automatic void model_step(input bit valid, input bit rx, input bit clr);
    bit pred, e;
    int ones;
    m_pulse = 1'b0;
    if (valid) begin
      pred = m_hist[0] ^ m_hist[4];
      if (!m_locked) begin
        if (m_fill == 9) begin
          ones = 0;
          foreach (m_hist[i]) ones += int'(m_hist[i]);
          if (rx == pred && ones != 0) m_match++;
          else                         m_match = 0;
        end
        m_hist.push_back(rx);
        void'(m_hist.pop_front());
        if (m_fill < 9) m_fill++;
        if (m_match == LOCK_THR) m_locked = 1'b1;
      end else begin
        e = rx ^ pred;
        m_hist.push_back(pred);
        void'(m_hist.pop_front());
        if (!clr) begin
          if (m_bc < CNT_MAX)      m_bc++;
          if (e && m_ec < CNT_MAX) m_ec++;
        end
        m_pulse = e;
        m_wbits++;
        m_werrs += int'(e);
        if (m_werrs >= ERR_THR) begin
          m_locked = 1'b0;
          m_fill   = 0;
          m_match  = 0;
          m_wbits  = 0;
          m_werrs  = 0;
        end else if (m_wbits == ERR_WIN) begin
          m_wbits = 0;
          m_werrs = 0;
        end
      end
    end
    if (clr) begin
      m_bc = 0;
      m_ec = 0;
    end
  endfunction

  // One cycle of stimulus; force_val >= 0 replaces the transmitter bit with a constant.
  task automatic sample(input bit flip, input bit [1:0] es, input bit en, input bit clr,
                        input bit rst, input int force_val = -1);
    bit   valid, rx;
    exp_t e;
    @(negedge clk);
    valid = en && (es == 2'b11);
    if (force_val >= 0) rx = force_val[0];
    else if (valid)     rx = tx_q[0] ^ flip;
    else                rx = 1'($urandom);
    if (valid) begin
      tx_q.push_back(tx_q[0] ^ tx_q[4]);
      void'(tx_q.pop_front());
    end
    bus.i_rx_bit        = rx;
    bus.i_enable_sample = es;
    bus.i_EnbRx         = en;
    bus.i_clr_cnt       = clr;
    i_rst               = rst;
    if (rst) model_reset();
    else     model_step(valid, rx, clr);
    e.lock    = m_locked;
    e.pulse   = m_pulse;
    e.bit_cnt = m_bc;
    e.err_cnt = m_ec;
    exp_q.push_back(e);
  endtask

  task automatic clean(input int n);
    repeat (n) sample(1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: the DUT presents a full status word every cycle; compare it against the model.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_lock",      bus.o_lock,      e.lock);
        check("sb_err_pulse", bus.o_err_pulse, e.pulse);
        check("sb_bit_cnt",   bus.o_bit_cnt,   e.bit_cnt);
        check("sb_err_cnt",   bus.o_err_cnt,   e.err_cnt);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         nvalid;
    bit   [1:0] es;
    bit         en;
    int         pflip;

    i_rst               = 1'b1;
    bus.i_rx_bit        = 1'b0;
    bus.i_enable_sample = 2'b00;
    bus.i_EnbRx         = 1'b0;
    bus.i_clr_cnt       = 1'b0;
    tx_q = '{1, 1, 0, 1, 0, 1, 0, 1, 0};
    model_reset();

    // Reset state.
    repeat (3) sample(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    settle();
    check("reset_lock",    bus.o_lock,      1'b0);
    check("reset_pulse",   bus.o_err_pulse, 1'b0);
    check("reset_bit_cnt", bus.o_bit_cnt,   0);
    check("reset_err_cnt", bus.o_err_cnt,   0);

    // Clean stream: lock the cycle after the 25th sample, then 1000 checked bits.
    clean(24);
    settle();
    check("no_lock_at_24", bus.o_lock, 1'b0);
    clean(1);
    settle();
    check("lock_at_25", bus.o_lock, 1'b1);
    clean(1000);
    settle();
    check("bit_cnt_1000", bus.o_bit_cnt, 1000);
    check("err_cnt_0",    bus.o_err_cnt, 0);

    // Single flipped bit at the start of a window: one error, lock held.
    clean(24);
    sample(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
    settle();
    check("single_err_pulse", bus.o_err_pulse, 1'b1);
    check("single_err_cnt",   bus.o_err_cnt,   1);
    check("single_err_lock",  bus.o_lock,      1'b1);
    clean(1);
    settle();
    check("single_pulse_drop", bus.o_err_pulse, 1'b0);
    clean(126);
    settle();
    check("no_followon_err", bus.o_err_cnt, 1);
    check("bit_cnt_1152",    bus.o_bit_cnt, 1152);

    // Eight errors inside one window: lock falls after the 8th, then relocks in 25 samples.
    repeat (7) sample(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
    settle();
    check("lock_after_7_err", bus.o_lock, 1'b1);
    sample(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
    settle();
    check("unlock_after_8_err", bus.o_lock,    1'b0);
    check("err_cnt_9",          bus.o_err_cnt, 9);
    clean(24);
    settle();
    check("relock_not_at_24", bus.o_lock, 1'b0);
    clean(1);
    settle();
    check("relock_at_25", bus.o_lock, 1'b1);

    // Constant streams never lock.
    sample(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    repeat (200) sample(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 0);
    settle();
    check("const0_no_lock", bus.o_lock, 1'b0);
    repeat (200) sample(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1);
    settle();
    check("const1_no_lock", bus.o_lock, 1'b0);

    // Strobe gaps: only en & es==11 consume bits.
    sample(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    nvalid = 0;
    repeat (600) begin
      es = 2'($urandom_range(0, 3));
      en = ($urandom_range(0, 3) != 0);
      sample(1'b0, es, en, 1'b0, 1'b0);
      if (en && es == 2'b11) nvalid++;
    end
    settle();
    check("gap_lock",    bus.o_lock,    1'b1);
    check("gap_bit_cnt", bus.o_bit_cnt, nvalid - 25);

    // Clear coincident with an error: counters zero, error not counted.
    sample(1'b1, 2'b11, 1'b1, 1'b1, 1'b0);
    settle();
    check("clr_bit_cnt", bus.o_bit_cnt, 0);
    check("clr_err_cnt", bus.o_err_cnt, 0);
    check("clr_lock",    bus.o_lock,    1'b1);
    clean(1);
    settle();
    check("post_clr_bit_cnt", bus.o_bit_cnt, 1);

    // Reset while locked.
    sample(1'b0, 2'b11, 1'b1, 1'b0, 1'b1);
    settle();
    check("rst_locked_lock",    bus.o_lock,    1'b0);
    check("rst_locked_bit_cnt", bus.o_bit_cnt, 0);
    check("rst_locked_err_cnt", bus.o_err_cnt, 0);

    // Randomised mix of gaps, error bursts, clears and occasional resets.
    for (int chunk = 0; chunk < 15; chunk++) begin
      pflip = $urandom_range(4, 60);
      repeat (200) begin
        es = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom_range(0, 2));
        en = ($urandom_range(0, 7) != 0);
        sample(($urandom_range(1, pflip) == 1), es, en,
               ($urandom_range(0, 199) == 0), ($urandom_range(0, 499) == 0));
      end
    end

    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
